avmm_emif16_master: RTL and testbench

- Avalon-MM slave that converts single 16-bit Avalon reads and writes into EMIF16 asynchronous-bus cycles: chip select, address, byte enables, write strobe, output-enable strobe and bidirectional data.
- It is the initiator-side counterpart of our EMIF16-to-Avalon bridge.
- Used as the host-side EMIF16 driver for loopback and bring-up of the FPGA EMIF16 target, and to access external async devices.
- Timing is set by programmable setup, strobe and hold counts, with optional extension by the EMIF WAIT pin.

---
 rtl/emif16_pkg.sv | 25 ++
 rtl/emif16_sync.sv | 24 ++
 rtl/avmm_emif16_master.sv | 186 ++++++++++++++++++
 tb/tb_avmm_emif16_master.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/emif16_pkg.sv
// Shared types and constants for the EMIF16 host-side master.
// State encoding, Avalon response codes and bus widths.
package emif16_pkg;

  localparam int EMIF16_AW = 24;
  localparam int EMIF16_DW = 16;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_EXT_WAIT,
    ST_HOLD
  } emif16_mst_state_t;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/emif16_sync.sv
// Multi-stage single-bit synchronizer.
// Async active-low reset clears every stage.
module emif16_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else begin
      sr_q <= {sr_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sr_q[STAGES-1];

endmodule

// File: rtl/avmm_emif16_master.sv
// Avalon-MM slave driving single EMIF16 async-bus cycles.
// Setup/strobe/hold timing with optional WAIT extension and timeout.
module avmm_emif16_master
  import emif16_pkg::*;
#(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int EXT_WAIT_EN   = 1,
  parameter int WAIT_TIMEOUT  = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [EMIF16_AW-1:0] avs_address_i,
  input  logic [EMIF16_DW-1:0] avs_writedata_i,
  input  logic [1:0]           avs_byteenable_i,
  input  logic                 avs_write_i,
  input  logic                 avs_read_i,
  output logic [EMIF16_DW-1:0] avs_readdata_o,
  output logic [1:0]           avs_response_o,
  output logic                 avs_waitrequest_o,
  inout  wire  [EMIF16_DW-1:0] e_data_io,
  output logic [EMIF16_AW-1:0] e_addr_o,
  output logic [1:0]           e_ben_o,
  output logic                 e_cen_o,
  output logic                 e_wen_o,
  output logic                 e_oen_o,
  input  logic                 e_wait_i
);

  localparam int CMAX =
    max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
  localparam int CW = $clog2(CMAX) + 1;
  localparam int TW = $clog2(WAIT_TIMEOUT) + 1;

  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TOUT_LD   = TW'(WAIT_TIMEOUT - 1);

  emif16_mst_state_t state_q, state_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          wait_s;
  logic          accept, capture, timeout;
  logic          wr_q, wr_d;
  logic          err_q, err_d;
  logic          last_d, strobe_d;
  logic [1:0]    ben_q, ben_d;
  logic [1:0]    resp_q, resp_d;
  logic          cen_q, wen_q, oen_q;
  logic          drive_q, wreq_q;

  logic [EMIF16_AW-1:0] addr_q;
  logic [EMIF16_DW-1:0] wdata_q, rdata_q;

  emif16_sync #(
    .STAGES(SYNC_STAGES)
  ) u_wait_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (e_wait_i),
    .q_o   (wait_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
    tcnt_d  = tcnt_q;
    accept  = 1'b0;
    capture = 1'b0;
    timeout = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (avs_write_i || avs_read_i) begin
          accept  = 1'b1;
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LD;
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          if (EXT_WAIT_EN != 0 && wait_s) begin
            state_d = ST_EXT_WAIT;
            tcnt_d  = TOUT_LD;
          end else begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LD;
            capture = 1'b1;
          end
        end
      end
      ST_EXT_WAIT: begin
        if (!wait_s || tcnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
          capture = 1'b1;
          timeout = wait_s;
        end else begin
          tcnt_d = tcnt_q - TW'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values for the next cycle, registered below.
  always_comb begin
    wr_d     = accept ? avs_write_i : wr_q;
    err_d    = accept ? 1'b0 : (err_q | timeout);
    last_d   = (state_d == ST_HOLD) && (cnt_d == '0);
    strobe_d = (state_d == ST_STROBE) ||
               (state_d == ST_EXT_WAIT);
    ben_d    = ben_q;
    if (state_d == ST_IDLE) begin
      ben_d = 2'b11;
    end else if (accept) begin
      ben_d = ~avs_byteenable_i;
    end
    resp_d = (last_d && err_d) ? RESP_SLVERR : RESP_OKAY;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      ben_q   <= 2'b11;
      resp_q  <= RESP_OKAY;
      cen_q   <= 1'b1;
      wen_q   <= 1'b1;
      oen_q   <= 1'b1;
      drive_q <= 1'b0;
      wreq_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      ben_q   <= ben_d;
      resp_q  <= resp_d;
      cen_q   <= (state_d == ST_IDLE);
      wen_q   <= !(strobe_d && wr_d);
      oen_q   <= !(strobe_d && !wr_d);
      drive_q <= (state_d != ST_IDLE) && wr_d;
      wreq_q  <= !last_d;
      if (accept) begin
        addr_q  <= avs_address_i;
        wdata_q <= avs_writedata_i;
      end
      if (capture && !wr_q) begin
        rdata_q <= e_data_io;
      end
    end
  end

  assign e_data_io         = drive_q ? wdata_q : 'z;
  assign e_addr_o          = addr_q;
  assign e_ben_o           = ben_q;
  assign e_cen_o           = cen_q;
  assign e_wen_o           = wen_q;
  assign e_oen_o           = oen_q;
  assign avs_readdata_o    = rdata_q;
  assign avs_response_o    = resp_q;
  assign avs_waitrequest_o = wreq_q;

endmodule

// File: tb/tb_avmm_emif16_master.sv
// Directed bench for avmm_emif16_master.
// Cycle 0 is the cycle a request is presented in IDLE.
module tb_avmm_emif16_master;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [23:0] address;
  logic [15:0] writedata;
  logic [1:0]  byteenable;
  logic        write, read;
  logic [15:0] readdata;
  logic [1:0]  response;
  logic        wreq;
  wire  [15:0] e_data;
  logic [23:0] e_addr;
  logic [1:0]  e_ben;
  logic        e_cen, e_wen, e_oen;
  logic        e_wait;

  // bus_mode 1: bench drives 0, or rd_val while OEn is low
  logic        bus_mode;
  logic [15:0] rd_val;

  int checks = 0;
  int errors = 0;

  assign e_data = bus_mode ? (e_oen ? 16'h0000 : rd_val) : 16'hzzzz;

  always #5 clk = ~clk;

  avmm_emif16_master #(
    .WAIT_TIMEOUT(16)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .avs_address_i    (address),
    .avs_writedata_i  (writedata),
    .avs_byteenable_i (byteenable),
    .avs_write_i      (write),
    .avs_read_i       (read),
    .avs_readdata_o   (readdata),
    .avs_response_o   (response),
    .avs_waitrequest_o(wreq),
    .e_data_io        (e_data),
    .e_addr_o         (e_addr),
    .e_ben_o          (e_ben),
    .e_cen_o          (e_cen),
    .e_wen_o          (e_wen),
    .e_oen_o          (e_oen),
    .e_wait_i         (e_wait)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(logic wr, logic [23:0] a,
                     logic [15:0] d, logic [1:0] be);
    write      = wr;
    read       = !wr;
    address    = a;
    writedata  = d;
    byteenable = be;
  endtask

  task automatic idle();
    write = 1'b0;
    read  = 1'b0;
  endtask

  initial begin
    rst_ni     = 1'b0;
    address    = '0;
    writedata  = '0;
    byteenable = '0;
    write      = 1'b0;
    read       = 1'b0;
    e_wait     = 1'b0;
    bus_mode   = 1'b1;
    rd_val     = 16'h0000;

    // reset state
    tick();
    chk("rst_cen", e_cen, 1);
    chk("rst_wen", e_wen, 1);
    chk("rst_oen", e_oen, 1);
    chk("rst_ben", e_ben, 2'b11);
    chk("rst_addr", e_addr, 0);
    chk("rst_wreq", wreq, 1);
    chk("rst_rdata", readdata, 0);
    chk("rst_resp", response, 0);
    chk("rst_bus", e_data, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    tick();

    // plain write
    bus_mode = 1'b0;
    req(1'b1, 24'h123456, 16'hA5C3, 2'b11);
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("wr_cen", e_cen, 0);
      chk("wr_wen", e_wen, (c >= 3 && c <= 6) ? 0 : 1);
      chk("wr_oen", e_oen, 1);
      chk("wr_wreq", wreq, (c == 8) ? 0 : 1);
      chk("wr_data", e_data, 16'hA5C3);
      chk("wr_ben", e_ben, 2'b00);
      chk("wr_addr", e_addr, 24'h123456);
    end
    chk("wr_resp", response, 2'b00);
    tick();
    idle();
    bus_mode = 1'b1;
    #1;
    chk("wr_end_cen", e_cen, 1);
    chk("wr_end_wreq", wreq, 1);
    chk("wr_end_bus", e_data, 0);

    // plain read
    rd_val = 16'hBEEF;
    req(1'b0, 24'h000100, 16'hFFFF, 2'b11);
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("rd_cen", e_cen, 0);
      chk("rd_oen", e_oen, (c >= 3 && c <= 6) ? 0 : 1);
      chk("rd_wen", e_wen, 1);
      chk("rd_wreq", wreq, (c == 8) ? 0 : 1);
      chk("rd_bus", e_data,
          (c >= 3 && c <= 6) ? 16'hBEEF : 16'h0000);
    end
    chk("rd_addr", e_addr, 24'h000100);
    chk("rd_data", readdata, 16'hBEEF);
    chk("rd_resp", response, 2'b00);
    tick();
    idle();

    // WAIT extension: wait drops 10 clocks after OEn falls
    e_wait = 1'b1;
    rd_val = 16'h1234;
    repeat (3) tick();
    req(1'b0, 24'h000200, 16'h0000, 2'b11);
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (c == 13) e_wait = 1'b0;
      chk("wt_oen", e_oen, (c >= 3 && c <= 15) ? 0 : 1);
      chk("wt_cen", e_cen, 0);
      chk("wt_wreq", wreq, (c == 17) ? 0 : 1);
    end
    chk("wt_data", readdata, 16'h1234);
    chk("wt_resp", response, 2'b00);
    tick();
    idle();

    // timeout with WAIT stuck high
    e_wait = 1'b1;
    rd_val = 16'h0F0F;
    repeat (3) tick();
    req(1'b0, 24'h000300, 16'h0000, 2'b11);
    for (int c = 1; c <= 24; c++) begin
      tick();
      chk("to_oen", e_oen, (c >= 3 && c <= 22) ? 0 : 1);
      chk("to_wreq", wreq, (c == 24) ? 0 : 1);
      chk("to_resp", response, (c == 24) ? 2'b10 : 2'b00);
    end
    chk("to_data", readdata, 16'h0F0F);
    tick();
    idle();
    e_wait = 1'b0;
    chk("to_end_resp", response, 2'b00);
    repeat (3) tick();

    // back-to-back write then read, byteenable 01
    bus_mode = 1'b0;
    req(1'b1, 24'h000400, 16'h1111, 2'b01);
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("bw_ben", e_ben, 2'b10);
      chk("bw_wreq", wreq, (c == 8) ? 0 : 1);
    end
    chk("bw_resp", response, 2'b00);
    tick();
    bus_mode = 1'b1;
    rd_val   = 16'h2222;
    req(1'b0, 24'h000401, 16'h0000, 2'b01);
    #1;
    chk("bb_gap_cen", e_cen, 1);
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("br_cen", e_cen, 0);
      chk("br_ben", e_ben, 2'b10);
      chk("br_oen", e_oen, (c >= 3 && c <= 6) ? 0 : 1);
      chk("br_wreq", wreq, (c == 8) ? 0 : 1);
    end
    chk("br_data", readdata, 16'h2222);
    chk("br_resp", response, 2'b00);
    tick();
    idle();

    // reset during the strobe of a write
    bus_mode = 1'b0;
    req(1'b1, 24'h000500, 16'h7777, 2'b11);
    for (int c = 1; c <= 4; c++) begin
      tick();
    end
    chk("rs_wen_pre", e_wen, 0);
    chk("rs_bus_pre", e_data, 16'h7777);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("rs_cen", e_cen, 1);
    chk("rs_wen", e_wen, 1);
    chk("rs_wreq", wreq, 1);
    chk("rs_ben", e_ben, 2'b11);
    idle();
    bus_mode = 1'b1;
    #1;
    chk("rs_bus", e_data, 0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    tick();
    chk("rs_idle_wreq", wreq, 1);
    chk("rs_idle_cen", e_cen, 1);
    rd_val = 16'h3C3C;
    req(1'b0, 24'h000600, 16'h0000, 2'b11);
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("rr_oen", e_oen, (c >= 3 && c <= 6) ? 0 : 1);
      chk("rr_wreq", wreq, (c == 8) ? 0 : 1);
    end
    chk("rr_data", readdata, 16'h3C3C);
    chk("rr_resp", response, 2'b00);
    tick();
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
